// File: rtl/alu_arbiter_if.sv
// ============================================================================
// alu_arbiter_if : two requester ports plus the shared ALU port of alu_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if;
    logic        i_r0_req;
    logic        i_r1_req;
    logic        o_r0_gnt;
    logic        o_r1_gnt;
    logic        o_r0_revoked;
    logic        o_r1_revoked;

    logic [1:0]  i_r0_input_op;
    logic        i_r0_data_valid;
    logic [31:0] i_r0_data;
    logic [1:0]  i_r0_output_op;
    logic        i_r0_result_empty;
    logic        o_r0_result_valid;
    logic [31:0] o_r0_result;
    logic [4:0]  o_r0_result_flags;

    logic [1:0]  i_r1_input_op;
    logic        i_r1_data_valid;
    logic [31:0] i_r1_data;
    logic [1:0]  i_r1_output_op;
    logic        i_r1_result_empty;
    logic        o_r1_result_valid;
    logic [31:0] o_r1_result;
    logic [4:0]  o_r1_result_flags;

    logic [1:0]  o_alu_input_op;
    logic        o_alu_data_valid;
    logic [31:0] o_alu_data;
    logic [1:0]  o_alu_output_op;
    logic        o_alu_result_empty;
    logic        i_alu_result_valid;
    logic [31:0] i_alu_result;
    logic [4:0]  i_alu_result_flags;

    modport slave (
        input  i_r0_req, i_r1_req,
        input  i_r0_input_op, i_r0_data_valid, i_r0_data, i_r0_output_op, i_r0_result_empty,
        input  i_r1_input_op, i_r1_data_valid, i_r1_data, i_r1_output_op, i_r1_result_empty,
        input  i_alu_result_valid, i_alu_result, i_alu_result_flags,
        output o_r0_gnt, o_r1_gnt, o_r0_revoked, o_r1_revoked,
        output o_r0_result_valid, o_r0_result, o_r0_result_flags,
        output o_r1_result_valid, o_r1_result, o_r1_result_flags,
        output o_alu_input_op, o_alu_data_valid, o_alu_data, o_alu_output_op, o_alu_result_empty
    );

    modport master (
        output i_r0_req, i_r1_req,
        output i_r0_input_op, i_r0_data_valid, i_r0_data, i_r0_output_op, i_r0_result_empty,
        output i_r1_input_op, i_r1_data_valid, i_r1_data, i_r1_output_op, i_r1_result_empty,
        output i_alu_result_valid, i_alu_result, i_alu_result_flags,
        input  o_r0_gnt, o_r1_gnt, o_r0_revoked, o_r1_revoked,
        input  o_r0_result_valid, o_r0_result, o_r0_result_flags,
        input  o_r1_result_valid, o_r1_result, o_r1_result_flags,
        input  o_alu_input_op, o_alu_data_valid, o_alu_data, o_alu_output_op, o_alu_result_empty
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : round-robin transaction-level arbiter sharing one ALU between
// two requesters. Optional hold timeout enabled by macro ALU_ARB_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int MAX_HOLD = 64
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst_n,
    alu_arbiter_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
        $error("alu_arbiter: MAX_HOLD must be in 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last;
    logic   r_gnt0;
    logic   r_gnt1;
    logic   w_req0;
    logic   w_req1;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_blk0;
    logic              r_blk1;
    logic              r_revoked0;
    logic              r_revoked1;
    logic              w_hold_max;

    // A revoked port stays out of arbitration until it has released its request
    assign w_req0     = bus.i_r0_req & ~r_blk0;
    assign w_req1     = bus.i_r1_req & ~r_blk1;
    assign w_hold_max = (r_hold == HOLD_W'(MAX_HOLD - 1));
`else
    assign w_req0 = bus.i_r0_req;
    assign w_req1 = bus.i_r1_req;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_hold     <= '0;
            r_blk0     <= 1'b0;
            r_blk1     <= 1'b0;
            r_revoked0 <= 1'b0;
            r_revoked1 <= 1'b0;
`endif
        end else begin
`ifdef ALU_ARB_TIMEOUT_EN
            r_revoked0 <= 1'b0;
            r_revoked1 <= 1'b0;
            if (!bus.i_r0_req) r_blk0 <= 1'b0;
            if (!bus.i_r1_req) r_blk1 <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
`ifdef ALU_ARB_TIMEOUT_EN
                    r_hold <= '0;
`endif
                    if (w_req0 && (!w_req1 || r_last)) begin
                        r_state <= OWN0;
                        r_last  <= 1'b0;
                        r_gnt0  <= 1'b1;
                    end else if (w_req1) begin
                        r_state <= OWN1;
                        r_last  <= 1'b1;
                        r_gnt1  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!bus.i_r0_req) begin
                        r_state <= IDLE;
                        r_gnt0  <= 1'b0;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (w_hold_max && w_req1) begin
                        r_state    <= IDLE;
                        r_gnt0     <= 1'b0;
                        r_revoked0 <= 1'b1;
                        r_blk0     <= 1'b1;
                    end else if (!w_hold_max) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
`endif
                end
                OWN1: begin
                    if (!bus.i_r1_req) begin
                        r_state <= IDLE;
                        r_gnt1  <= 1'b0;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (w_hold_max && w_req0) begin
                        r_state    <= IDLE;
                        r_gnt1     <= 1'b0;
                        r_revoked1 <= 1'b1;
                        r_blk1     <= 1'b1;
                    end else if (!w_hold_max) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    logic [1:0]  w_alu_input_op;
    logic        w_alu_data_valid;
    logic [31:0] w_alu_data;
    logic [1:0]  w_alu_output_op;
    logic        w_alu_result_empty;

    // Owner whose request is low already sees a zeroed mux in its release cycle
    always_comb begin
        w_alu_input_op     = 2'b00;
        w_alu_data_valid   = 1'b0;
        w_alu_data         = 32'h0;
        w_alu_output_op    = 2'b00;
        w_alu_result_empty = 1'b0;
        if (r_state == OWN0 && bus.i_r0_req) begin
            w_alu_input_op     = bus.i_r0_input_op;
            w_alu_data_valid   = bus.i_r0_data_valid;
            w_alu_data         = bus.i_r0_data;
            w_alu_output_op    = bus.i_r0_output_op;
            w_alu_result_empty = bus.i_r0_result_empty;
        end else if (r_state == OWN1 && bus.i_r1_req) begin
            w_alu_input_op     = bus.i_r1_input_op;
            w_alu_data_valid   = bus.i_r1_data_valid;
            w_alu_data         = bus.i_r1_data;
            w_alu_output_op    = bus.i_r1_output_op;
            w_alu_result_empty = bus.i_r1_result_empty;
        end
    end

    assign bus.o_alu_input_op     = w_alu_input_op;
    assign bus.o_alu_data_valid   = w_alu_data_valid;
    assign bus.o_alu_data         = w_alu_data;
    assign bus.o_alu_output_op    = w_alu_output_op;
    assign bus.o_alu_result_empty = w_alu_result_empty;

    assign bus.o_r0_gnt          = r_gnt0;
    assign bus.o_r1_gnt          = r_gnt1;
    assign bus.o_r0_result_valid = bus.i_alu_result_valid & r_gnt0;
    assign bus.o_r1_result_valid = bus.i_alu_result_valid & r_gnt1;
    assign bus.o_r0_result       = bus.i_alu_result;
    assign bus.o_r1_result       = bus.i_alu_result;
    assign bus.o_r0_result_flags = bus.i_alu_result_flags;
    assign bus.o_r1_result_flags = bus.i_alu_result_flags;

`ifdef ALU_ARB_TIMEOUT_EN
    assign bus.o_r0_revoked = r_revoked0;
    assign bus.o_r1_revoked = r_revoked1;
`else
    assign bus.o_r0_revoked = 1'b0;
    assign bus.o_r1_revoked = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed self-checking bench for alu_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_arbiter_if bus();

    alu_arbiter #(.MAX_HOLD(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_r0_req = 0;            bus.i_r1_req = 0;
        bus.i_r0_input_op = 0;       bus.i_r1_input_op = 0;
        bus.i_r0_data_valid = 0;     bus.i_r1_data_valid = 0;
        bus.i_r0_data = 0;           bus.i_r1_data = 0;
        bus.i_r0_output_op = 0;      bus.i_r1_output_op = 0;
        bus.i_r0_result_empty = 0;   bus.i_r1_result_empty = 0;
        bus.i_alu_result_valid = 0;  bus.i_alu_result = 0;
        bus.i_alu_result_flags = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.i_r0_req = 1; bus.i_r0_data_valid = 1; bus.i_r0_data = 32'h1;
        bus.i_alu_result_valid = 1;
        step();
        step();
        tests++; if (bus.o_r0_gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt0: got %b want 0", bus.o_r0_gnt); end
        tests++; if (bus.o_r1_gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt1: got %b want 0", bus.o_r1_gnt); end
        tests++; if ({bus.o_r0_revoked, bus.o_r1_revoked} !== 2'b00) begin fails++; $display("FAIL reset_revoked: got %b want 00", {bus.o_r0_revoked, bus.o_r1_revoked}); end
        tests++; if ({bus.o_alu_data_valid, bus.o_alu_data} !== 33'h0) begin fails++; $display("FAIL reset_alu: got %h want 0", {bus.o_alu_data_valid, bus.o_alu_data}); end
        tests++; if (bus.o_r0_result_valid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", bus.o_r0_result_valid); end
        clear_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_grant();
        apply_reset();
        step();
        bus.i_r0_req = 1;
        #1;
        tests++; if (bus.o_r0_gnt !== 1'b0) begin fails++; $display("FAIL gnt_latency: got %b want 0", bus.o_r0_gnt); end
        step();
        tests++; if (bus.o_r0_gnt !== 1'b1) begin fails++; $display("FAIL gnt_rise: got %b want 1", bus.o_r0_gnt); end
        bus.i_r0_data = 32'h0000_00AA; bus.i_r0_data_valid = 1; bus.i_r0_input_op = 2'd2;
        bus.i_r0_output_op = 2'd1; bus.i_r0_result_empty = 1;
        #1;
        tests++; if (bus.o_alu_data !== 32'hAA) begin fails++; $display("FAIL alu_data: got %h want 000000aa", bus.o_alu_data); end
        tests++; if ({bus.o_alu_data_valid, bus.o_alu_input_op, bus.o_alu_output_op, bus.o_alu_result_empty} !== 6'b1_10_01_1)
            begin fails++; $display("FAIL alu_strobes: got %b want 110011", {bus.o_alu_data_valid, bus.o_alu_input_op, bus.o_alu_output_op, bus.o_alu_result_empty}); end
        bus.i_alu_result_valid = 1; bus.i_alu_result = 32'h1234_5678; bus.i_alu_result_flags = 5'h15;
        #1;
        tests++; if ({bus.o_r0_result_valid, bus.o_r1_result_valid} !== 2'b10) begin fails++; $display("FAIL result_valid: got %b want 10", {bus.o_r0_result_valid, bus.o_r1_result_valid}); end
        tests++; if (bus.o_r1_result !== 32'h1234_5678) begin fails++; $display("FAIL result_mirror: got %h want 12345678", bus.o_r1_result); end
        tests++; if (bus.o_r0_result_flags !== 5'h15) begin fails++; $display("FAIL result_flags: got %h want 15", bus.o_r0_result_flags); end
        bus.i_r0_req = 0;
        #1;
        tests++; if (bus.o_alu_data_valid !== 1'b0) begin fails++; $display("FAIL release_mux: got %b want 0", bus.o_alu_data_valid); end
        tests++; if (bus.o_r0_gnt !== 1'b1) begin fails++; $display("FAIL release_hold: got %b want 1", bus.o_r0_gnt); end
        step();
        tests++; if (bus.o_r0_gnt !== 1'b0) begin fails++; $display("FAIL release_gnt: got %b want 0", bus.o_r0_gnt); end
        clear_inputs();
    endtask

    task automatic test_tie_and_release();
        apply_reset();
        bus.i_r0_req = 1; bus.i_r1_req = 1;
        step();
        tests++; if ({bus.o_r1_gnt, bus.o_r0_gnt} !== 2'b01) begin fails++; $display("FAIL tie_first: got %b want 01", {bus.o_r1_gnt, bus.o_r0_gnt}); end
        step(); step(); step();
        tests++; if ({bus.o_r1_gnt, bus.o_r0_gnt} !== 2'b01) begin fails++; $display("FAIL tie_hold: got %b want 01", {bus.o_r1_gnt, bus.o_r0_gnt}); end
        bus.i_r0_req = 0;
        step();
        tests++; if ({bus.o_r1_gnt, bus.o_r0_gnt} !== 2'b00) begin fails++; $display("FAIL tie_turnaround: got %b want 00", {bus.o_r1_gnt, bus.o_r0_gnt}); end
        step();
        tests++; if ({bus.o_r1_gnt, bus.o_r0_gnt} !== 2'b10) begin fails++; $display("FAIL tie_second: got %b want 10", {bus.o_r1_gnt, bus.o_r0_gnt}); end
        clear_inputs();
        step();
    endtask

    task automatic test_isolation();
        apply_reset();
        bus.i_r0_req = 1;
        step();
        bus.i_r1_req = 1; bus.i_r1_data_valid = 1; bus.i_r1_data = 32'h55; bus.i_r1_input_op = 2'd3;
        bus.i_r1_result_empty = 1; bus.i_r1_output_op = 2'd2; bus.i_alu_result_valid = 1;
        #1;
        tests++; if ({bus.o_alu_input_op, bus.o_alu_data_valid, bus.o_alu_data, bus.o_alu_output_op, bus.o_alu_result_empty} !== 38'h0)
            begin fails++; $display("FAIL iso_alu: got %h want 0", {bus.o_alu_input_op, bus.o_alu_data_valid, bus.o_alu_data, bus.o_alu_output_op, bus.o_alu_result_empty}); end
        tests++; if ({bus.o_r0_result_valid, bus.o_r1_result_valid} !== 2'b10) begin fails++; $display("FAIL iso_rvalid: got %b want 10", {bus.o_r0_result_valid, bus.o_r1_result_valid}); end
        bus.i_r0_req = 0;
        step();
        tests++; if (bus.o_alu_data_valid !== 1'b0) begin fails++; $display("FAIL iso_idle_mux: got %b want 0", bus.o_alu_data_valid); end
        step();
        tests++; if ({bus.o_alu_data_valid, bus.o_alu_input_op, bus.o_alu_data} !== {1'b1, 2'd3, 32'h55})
            begin fails++; $display("FAIL iso_own1_mux: got %h want %h", {bus.o_alu_data_valid, bus.o_alu_input_op, bus.o_alu_data}, {1'b1, 2'd3, 32'h55}); end
        tests++; if ({bus.o_r0_result_valid, bus.o_r1_result_valid} !== 2'b01) begin fails++; $display("FAIL iso_own1_rvalid: got %b want 01", {bus.o_r0_result_valid, bus.o_r1_result_valid}); end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        apply_reset();
        bus.i_r0_req = 1; bus.i_r1_req = 1;
        step();
        for (int t = 0; t < 20; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            for (int c = 0; c < 3; c++) begin
                tests++; if ({bus.o_r1_gnt, bus.o_r0_gnt} !== exp_g) begin fails++; $display("FAIL b2b_own t=%0d c=%0d: got %b want %b", t, c, {bus.o_r1_gnt, bus.o_r0_gnt}, exp_g); end
                if (c < 2) step();
            end
            if (t % 2 == 0) bus.i_r0_req = 0; else bus.i_r1_req = 0;
            step();
            tests++; if ({bus.o_r1_gnt, bus.o_r0_gnt} !== 2'b00) begin fails++; $display("FAIL b2b_idle t=%0d: got %b want 00", t, {bus.o_r1_gnt, bus.o_r0_gnt}); end
            bus.i_r0_req = 1; bus.i_r1_req = 1;
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.i_r1_req = 1; bus.i_r1_data_valid = 1; bus.i_r1_data = 32'hDEAD_BEEF;
        step();
        tests++; if ({bus.o_r1_gnt, bus.o_alu_data_valid} !== 2'b11) begin fails++; $display("FAIL areset_pre: got %b want 11", {bus.o_r1_gnt, bus.o_alu_data_valid}); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if ({bus.o_r1_gnt, bus.o_alu_data_valid} !== 2'b00) begin fails++; $display("FAIL areset_drop: got %b want 00", {bus.o_r1_gnt, bus.o_alu_data_valid}); end
        #2;
        rst_n = 1'b1;
        #1;
        tests++; if (bus.o_r1_gnt !== 1'b0) begin fails++; $display("FAIL areset_idle: got %b want 0", bus.o_r1_gnt); end
        step();
        tests++; if (bus.o_r1_gnt !== 1'b1) begin fails++; $display("FAIL areset_regrant: got %b want 1", bus.o_r1_gnt); end
        clear_inputs();
        step();
    endtask

`ifdef ALU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        pulses = 0;
        apply_reset();
        bus.i_r0_req = 1;
        step();
        bus.i_r1_req = 1;
        for (int k = 1; k < 8; k++) begin
            if (bus.o_r0_revoked) pulses++;
            step();
        end
        tests++; if ({bus.o_r0_gnt, bus.o_r0_revoked} !== 2'b10) begin fails++; $display("FAIL to_cycle8: got %b want 10", {bus.o_r0_gnt, bus.o_r0_revoked}); end
        step();
        tests++; if ({bus.o_r1_gnt, bus.o_r0_gnt, bus.o_r0_revoked} !== 3'b001) begin fails++; $display("FAIL to_revoke: got %b want 001", {bus.o_r1_gnt, bus.o_r0_gnt, bus.o_r0_revoked}); end
        if (bus.o_r0_revoked) pulses++;
        step();
        if (bus.o_r0_revoked) pulses++;
        tests++; if ({bus.o_r1_gnt, bus.o_r0_gnt} !== 2'b10) begin fails++; $display("FAIL to_handover: got %b want 10", {bus.o_r1_gnt, bus.o_r0_gnt}); end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL to_pulses: got %0d want 1", pulses); end
        bus.i_r1_req = 0;
        step();
        step();
        tests++; if (bus.o_r0_gnt !== 1'b0) begin fails++; $display("FAIL to_blocked: got %b want 0", bus.o_r0_gnt); end
        bus.i_r0_req = 0;
        step();
        bus.i_r0_req = 1;
        step();
        tests++; if (bus.o_r0_gnt !== 1'b1) begin fails++; $display("FAIL to_unblocked: got %b want 1", bus.o_r0_gnt); end
        clear_inputs();
        step();
    endtask
`else
    task automatic test_no_timeout();
        apply_reset();
        bus.i_r0_req = 1;
        step();
        bus.i_r1_req = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            tests++; if ({bus.o_r0_gnt, bus.o_r1_gnt, bus.o_r0_revoked} !== 3'b100) begin fails++; $display("FAIL unbounded k=%0d: got %b want 100", k, {bus.o_r0_gnt, bus.o_r1_gnt, bus.o_r0_revoked}); end
        end
        clear_inputs();
        step();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_grant();
        test_tie_and_release();
        test_isolation();
        test_back_to_back();
        test_async_reset();
`ifdef ALU_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
